// File: rtl/sort_median_stream.sv
// Sliding-window rank filter: median/min/max of the last WIN samples via a pipelined
// odd-even transposition network. Define SORT_FULL_OUT_EN to expose the full sorted window.
module sort_median_stream #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned WIN    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_num,
    input  logic [1:0]        in_mode,
    input  logic              in_clear,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_num
`ifdef SORT_FULL_OUT_EN
    ,
    output logic [WIN*DATA_W-1:0] out_sorted
`endif
);

    localparam int unsigned VEC_W   = WIN * DATA_W;
    localparam int unsigned HIST_W  = (WIN - 1) * DATA_W;
    localparam int unsigned CNT_W   = $clog2(WIN + 1);
    localparam int unsigned IDX_W   = $clog2(WIN);
    localparam int unsigned NSTG    = WIN - 1;
    localparam int unsigned MED_IDX = (WIN - 1) / 2;

    // One compare-exchange layer; odd selects pairs (1,2),(3,4)... instead of (0,1),(2,3)...
    function automatic logic [VEC_W-1:0] oet_layer(input logic [VEC_W-1:0] v, input logic odd);
        logic [VEC_W-1:0]  r;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        r = v;
        for (int i = 0; i < int'(WIN) - 1; i++) begin
            if (i[0] == odd) begin
                a = v[i*DATA_W +: DATA_W];
                b = v[(i+1)*DATA_W +: DATA_W];
                if (a > b) begin
                    r[i*DATA_W +: DATA_W]     = b;
                    r[(i+1)*DATA_W +: DATA_W] = a;
                end
            end
        end
        return r;
    endfunction

    // The oldest window entry only ever feeds stage 1, so history holds WIN-1 samples.
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [VEC_W-1:0]  stg_q  [NSTG];
    logic [VEC_W-1:0]  stg_d  [NSTG];
    logic [1:0]        mode_q [NSTG];
    logic [1:0]        mode_d [NSTG];
    logic [NSTG-1:0]   vld_q, vld_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_num_q, out_num_d;

    logic              accept_c;
    logic              complete_c;
    logic [VEC_W-1:0]  shifted_c;
    logic [VEC_W-1:0]  final_c;
    logic [DATA_W-1:0] fin_arr_c [WIN];
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] rank_c;

`ifdef SORT_FULL_OUT_EN
    logic [VEC_W-1:0]  out_sorted_q, out_sorted_d;
    assign out_sorted = out_sorted_q;
`endif

    assign out_valid = out_valid_q;
    assign out_num   = out_num_q;

    // Window shift, fill count and pipeline advance
    always_comb begin
        accept_c   = in_valid & ~in_clear;
        shifted_c  = {hist_q, in_num};
        complete_c = (cnt_q >= CNT_W'(WIN - 1));
        hist_d     = hist_q;
        cnt_d      = cnt_q;
        if (in_clear) begin
            hist_d = '0;
            cnt_d  = '0;
        end else if (accept_c) begin
            hist_d = shifted_c[HIST_W-1:0];
            if (cnt_q != CNT_W'(WIN)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        stg_d[0]  = oet_layer(shifted_c, 1'b0);
        mode_d[0] = in_mode;
        vld_d     = '0;
        vld_d[0]  = accept_c & complete_c;
        for (int s = 1; s < int'(NSTG); s++) begin
            stg_d[s]  = oet_layer(stg_q[s-1], s[0]);
            mode_d[s] = mode_q[s-1];
            vld_d[s]  = vld_q[s-1] & ~in_clear;
        end
    end

    // Last layer, rank select and output capture
    always_comb begin
        final_c = oet_layer(stg_q[NSTG-1], 1'(NSTG % 2));
        for (int i = 0; i < int'(WIN); i++) begin
            fin_arr_c[i] = final_c[i*DATA_W +: DATA_W];
        end
        case (mode_q[NSTG-1])
            2'b01:   idx_c = '0;
            2'b10:   idx_c = IDX_W'(WIN - 1);
            default: idx_c = IDX_W'(MED_IDX);
        endcase
        rank_c      = fin_arr_c[idx_c];
        out_valid_d = vld_q[NSTG-1] & ~in_clear;
        out_num_d   = out_valid_d ? rank_c : out_num_q;
`ifdef SORT_FULL_OUT_EN
        out_sorted_d = out_valid_d ? final_c : out_sorted_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            cnt_q       <= '0;
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_num_q   <= '0;
            for (int s = 0; s < int'(NSTG); s++) begin
                stg_q[s]  <= '0;
                mode_q[s] <= '0;
            end
`ifdef SORT_FULL_OUT_EN
            out_sorted_q <= '0;
`endif
        end else begin
            hist_q      <= hist_d;
            cnt_q       <= cnt_d;
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            out_num_q   <= out_num_d;
            for (int s = 0; s < int'(NSTG); s++) begin
                stg_q[s]  <= stg_d[s];
                mode_q[s] <= mode_d[s];
            end
`ifdef SORT_FULL_OUT_EN
            out_sorted_q <= out_sorted_d;
`endif
        end
    end

endmodule

// File: doc/sort_median_stream.md
# sort_median_stream

Streaming sliding-window rank filter: accepts one DATA_W-bit sample per valid cycle, keeps the last WIN samples, and returns the median, minimum or maximum of that window through a fully pipelined odd-even transposition sorting network. It generalises the team's 5-input combinational median sorter to a parametrised, registered, back-to-back-throughput block. It sits between the sample source and the downstream consumer on a valid-only interface with no backpressure.

## Interface
- DATA_W, 6: sample width in bits, 2..16.
- WIN, 5: window length, odd, 3..9.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample strobe; in_num is accepted on every rising edge where in_valid=1.
- in_num  in  DATA_W  unsigned sample.
- in_mode  in  2  rank select, sampled with the sample: 00 median, 01 min, 10 max, 11 median.
- in_clear  in  1  synchronous window flush; it has priority over in_valid.
- out_valid  out  1  one-cycle strobe marking out_num valid.
- out_num  out  DATA_W  selected rank of the window.
- out_sorted  out  WIN*DATA_W  ascending sorted window, element 0 in the LSBs. Present only with SORT_FULL_OUT_EN.

## Operation
- Window register win[0..WIN-1], where win[0] is the newest sample. On an accept: win[i] <= win[i-1], win[0] <= in_num.
- Fill counter cnt saturates at WIN and increments on each accept. A sample is "complete" when cnt after the accept equals WIN. Only complete samples produce out_valid.
- Pipeline:
  - Stage 1 registers the post-shift window.
  - Stages 2..WIN each register one odd-even transposition layer. Layer parity alternates, starting with even pairs (0,1),(2,3)...
  - After layer WIN the data is fully sorted ascending.
  - Each stage carries a valid bit (complete AND accepted) and the 2-bit mode.
- Output rank: median = sorted[(WIN-1)/2], min = sorted[0], max = sorted[WIN-1].
- Compare rule is unsigned a <= b, keeping the existing order. Equal values are stable, and duplicates are legal.
- in_clear:
  - win, cnt and all stage valid bits go to 0 at the next edge.
  - in_valid in the same cycle is ignored.
  - Data in flight is discarded and out_valid stays low.
- in_mode changes take effect only for samples accepted after the change. In-flight results keep their own mode.
- Gaps in in_valid are allowed. Stage valid bits advance every cycle regardless of in_valid.

## Timing
- Reset values: every win entry 0, cnt 0, all stage valids 0, out_valid 0, out_num 0, out_sorted 0.
- Latency: a sample accepted at edge k produces its result after edge k+WIN-1, so out_valid is high during the cycle following that edge. That is WIN cycles, 5 at the default.
- Throughput is one result per cycle with continuous in_valid.
- out_valid is high exactly one cycle per complete sample. out_num and out_sorted hold their last value while out_valid=0.
- Warm-up: the first WIN-1 samples after reset or clear never raise out_valid.
- Reset asserted mid-stream takes effect immediately and asynchronously. After release, the first out_valid needs WIN new samples.
- A cycle with in_clear=1 and in_valid=1 counts as a clear only.

## Configuration
- SORT_FULL_OUT_EN defined:
  - out_sorted exists and is driven from the last stage.
  - The final stage registers all WIN elements.
- SORT_FULL_OUT_EN undefined:
  - out_sorted is absent.
  - The final stage keeps only the elements needed for min, median and max.
  - Behaviour of out_num and out_valid is identical in both builds.

## Test plan
- Basic median (WIN=5, DATA_W=6, mode 00): send 10,3,60,7,25 back-to-back -> single out_valid 5 cycles after the last accept, out_num=10. Then send 0 -> out_num=7.
- Modes: window 3,60,7,25,0 with the last sample tagged mode 10 -> 60. Next sample 40 tagged 01 -> 0. An earlier in-flight median result is unaffected.
- Warm-up and gaps: send 4 samples with idle cycles between them -> no out_valid. The 5th sample -> exactly one out_valid; all 63s -> out_num=63.
- Clear: after 7 samples, pulse in_clear together with in_valid=1 -> no out_valid for in-flight data. The next 4 samples produce nothing and the 5th produces a result; the clear-cycle sample is never counted.
- Reset mid-pipeline: drop rst_n while 3 results are in flight -> out_valid=0 and out_num=0 immediately, with no stale output after release.
- With SORT_FULL_OUT_EN defined: window 10,3,60,7,25 -> out_sorted = {60,25,10,7,3} in MSB to LSB order.
